// File: rtl/mdu_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed XLEN+2 cycle latency from accepted START to DONE.
module mdu_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALUOP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic [4:0]      DEST_IN,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      DEST_OUT
);

    // state | meaning
    // IDLE  | waiting for START with an M-extension ALUOP
    // CALC  | one multiply/divide iteration per cycle, XLEN cycles
    // FIX   | sign-correct and register the selected result
    // FIN   | DONE pulse; RESULT/DEST_OUT valid
    typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [2:0]        op;
    logic              neg_res, neg_rem;
    logic [4:0]        dest;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, div_step, prod;
    logic [XLEN+1:0]   div_diff;
    logic              div_neg;
    logic [XLEN-1:0]   quo, rem, fix_res;

    assign accept   = START && (ALUOP[4:3] == 2'b01) && !FLUSH;
    assign a_signed = ALUOP[2] ? !ALUOP[1] : (ALUOP[1:0] != 2'b11);
    assign b_signed = !ALUOP[1];
    assign a_neg    = a_signed && DATA1[XLEN-1];
    assign b_neg    = b_signed && DATA2[XLEN-1];
    assign a_mag    = a_neg ? -DATA1 : DATA1;
    assign b_mag    = b_neg ? -DATA2 : DATA2;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_step = {mul_sum, acc[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}.
    // A zero divisor always "succeeds", giving all-ones quotient and rem = dividend.
    assign div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, opb};
    assign div_neg  = div_diff[XLEN+1];
    assign div_step = {div_neg ? acc[2*XLEN-2:XLEN-1] : div_diff[XLEN-1:0],
                       acc[XLEN-2:0], !div_neg};

    assign prod = neg_res ? -acc : acc;
    assign quo  = acc[XLEN-1:0];
    assign rem  = acc[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = '0;
        case (op)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b110:         fix_res = neg_res ? -quo : quo;
            default:                fix_res = neg_rem ? -rem : rem;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (FLUSH)                           state_nxt = IDLE;
                else if (cnt == CNT_W'(XLEN - 1))    state_nxt = FIX;
            end
            FIX:  state_nxt = FLUSH ? IDLE : FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            op       <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dest     <= '0;
            RESULT   <= '0;
            DEST_OUT <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    op      <= ALUOP[2:0];
                    dest    <= DEST_IN;
                    cnt     <= '0;
                    neg_rem <= a_neg;
                    if (ALUOP[2]) begin
                        acc     <= {{XLEN{1'b0}}, a_mag};
                        opb     <= b_mag;
                        // quotient keeps all-ones on divide by zero
                        neg_res <= (a_neg ^ b_neg) && (DATA2 != '0);
                    end else begin
                        acc     <= {{XLEN{1'b0}}, b_mag};
                        opb     <= a_mag;
                        neg_res <= a_neg ^ b_neg;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= op[2] ? div_step : mul_step;
                end
                FIX: if (!FLUSH) begin
                    RESULT   <= fix_res;
                    DEST_OUT <= dest;
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, results, flush, reset and ignored starts.
module tb_mdu_unit;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [4:0]  ALUOP, DEST_IN, DEST_OUT;
    logic [31:0] DATA1, DATA2, RESULT;
    logic        BUSY, DONE;

    int n_cmp = 0;
    int n_err = 0;

    mdu_unit #(.XLEN(32), .CNT_W(6)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ALUOP(ALUOP),
        .DATA1(DATA1), .DATA2(DATA2), .DEST_IN(DEST_IN), .FLUSH(FLUSH),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .DEST_OUT(DEST_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op at E0, sample before each edge E1..E36, check timing and result.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp);
        int first_done, n_done, busy_bad;
        first_done = 0; n_done = 0; busy_bad = 0;
        @(negedge CLK);
        START = 1'b1; ALUOP = op; DATA1 = a; DATA2 = b; DEST_IN = d;
        @(posedge CLK);
        for (int k = 1; k <= 36; k++) begin
            @(negedge CLK);
            if (k == 1) START = 1'b0;
            if (DONE === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (BUSY !== (k <= 34)) busy_bad++;
        end
        check({tag, "_done_at"}, first_done, 34);
        check({tag, "_done_cnt"}, n_done, 1);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_result"}, RESULT, exp);
        check({tag, "_dest"}, {27'b0, DEST_OUT}, {27'b0, d});
    endtask

    initial begin
        int n_done, busy_bad;
        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        ALUOP = '0; DATA1 = '0; DATA2 = '0; DEST_IN = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check("rst_busy", {31'b0, BUSY}, 32'd0);
        check("rst_done", {31'b0, DONE}, 32'd0);
        check("rst_result", RESULT, 32'd0);
        check("rst_dest", {27'b0, DEST_OUT}, 32'd0);

        run_op("mul",    5'b01000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
        run_op("mulh",   5'b01001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000);
        run_op("mulhu",  5'b01011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE);
        run_op("mulhsu", 5'b01010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF);
        run_op("div",    5'b01100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD);
        run_op("rem",    5'b01101, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF);
        run_op("divu",   5'b01110, 32'd100,      32'd7,        5'd11, 32'd14);
        run_op("remu",   5'b01111, 32'd100,      32'd7,        5'd12, 32'd2);
        run_op("div_ovf", 5'b01100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000);
        run_op("rem_ovf", 5'b01101, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0);
        run_op("remu_z", 5'b01111, 32'd5,        32'd0,        5'd15, 32'd5);
        run_op("div_z",  5'b01100, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF);

        // mul 3*4, ignored START at E10, FLUSH at E20
        n_done = 0;
        @(negedge CLK);
        START = 1'b1; ALUOP = 5'b01000; DATA1 = 32'd3; DATA2 = 32'd4; DEST_IN = 5'd20;
        @(posedge CLK);
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            START = 1'b0; FLUSH = 1'b0;
            if (k == 10) begin
                START = 1'b1; ALUOP = 5'b01100; DATA1 = 32'd9; DATA2 = 32'd3;
            end
            if (k == 20) FLUSH = 1'b1;
            if (k == 20) check("flush_busy_before", {31'b0, BUSY}, 32'd1);
            if (k == 21) check("flush_busy_after", {31'b0, BUSY}, 32'd0);
            if (DONE === 1'b1) n_done++;
        end
        check("flush_no_done", n_done, 0);
        check("flush_result_kept", RESULT, 32'hFFFFFFFF);
        check("flush_dest_kept", {27'b0, DEST_OUT}, 32'd16);

        run_op("div_after_flush", 5'b01100, 32'd9, 32'd3, 5'd21, 32'd3);

        // reset in the middle of a multiply
        @(negedge CLK);
        START = 1'b1; ALUOP = 5'b01000; DATA1 = 32'd6; DATA2 = 32'd7; DEST_IN = 5'd3;
        @(posedge CLK);
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        check("mid_busy", {31'b0, BUSY}, 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("rst_mid_busy", {31'b0, BUSY}, 32'd0);
        check("rst_mid_done", {31'b0, DONE}, 32'd0);
        check("rst_mid_result", RESULT, 32'd0);
        check("rst_mid_dest", {27'b0, DEST_OUT}, 32'd0);

        // non-M ALUOP, then valid op with FLUSH: both ignored in IDLE
        busy_bad = 0;
        START = 1'b1; ALUOP = 5'b00000; DATA1 = 32'd1; DATA2 = 32'd1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (BUSY !== 1'b0) busy_bad++;
        end
        check("bad_op_ignored", busy_bad, 0);
        busy_bad = 0;
        START = 1'b1; FLUSH = 1'b1; ALUOP = 5'b01000;
        @(negedge CLK);
        START = 1'b0; FLUSH = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (BUSY !== 1'b0) busy_bad++;
        end
        check("start_flush_ignored", busy_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
